// File: rtl/div_rr_scheduler.sv
// Two-requester restoring divider with one shared engine.
// Round-robin grant in IDLE, one quotient bit per CALC cycle, held result in RESP.
module div_rr_scheduler #(
    parameter int width = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [width-1:0] req0_a,
    input  logic [width-1:0] req0_b,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [width-1:0] req1_a,
    input  logic [width-1:0] req1_b,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic             rsp_id,
    output logic [width-1:0] rsp_q,
    output logic [width-1:0] rsp_r,
    output logic             rsp_dbz,
    output logic             busy
);

    localparam int CW = $clog2(width + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_CALC,
        S_RESP
    } state_t;

    state_t           r_state;
    state_t           w_next;
    logic [CW-1:0]    r_cnt;
    logic             r_ptr;
    logic             r_id;
    logic             r_rsp_id;
    logic [width-1:0] r_b;
    logic [width-1:0] r_rem;
    logic [width-1:0] r_quo;
    logic             r_dbz;

    logic             w_idle;
    logic             w_gnt0;
    logic             w_gnt1;
    logic             w_acc;
    logic             w_acc_id;
    logic [width-1:0] w_acc_a;
    logic [width-1:0] w_acc_b;
    logic             w_last;
    logic [width:0]   w_sh;
    logic [width:0]   w_trial;
    logic             w_fit;

    // r_ptr holds the last granted requester; a tie goes to the other one.
    assign w_idle   = (r_state == S_IDLE);
    assign w_gnt1   = req1_valid & (~req0_valid | ~r_ptr);
    assign w_gnt0   = req0_valid & ~w_gnt1;
    assign req0_ready = w_idle & w_gnt0;
    assign req1_ready = w_idle & w_gnt1;
    assign w_acc    = (req0_valid & req0_ready) | (req1_valid & req1_ready);
    assign w_acc_id = req1_ready;
    assign w_acc_a  = w_acc_id ? req1_a : req0_a;
    assign w_acc_b  = w_acc_id ? req1_b : req0_b;
    assign w_last   = (r_cnt == CW'(1));

    assign w_sh    = {r_rem, r_quo[width-1]};
    assign w_trial = w_sh - {1'b0, r_b};
    assign w_fit   = ~w_trial[width];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next    = r_state;
        rsp_valid = 1'b0;
        rsp_q     = '0;
        rsp_r     = '0;
        rsp_dbz   = 1'b0;
        busy      = 1'b1;
        unique case (r_state)
            S_IDLE: begin
                busy = 1'b0;
                if (w_acc) begin
                    w_next = (w_acc_b == '0) ? S_RESP : S_CALC;
                end
            end
            S_CALC: begin
                if (w_last) begin
                    w_next = S_RESP;
                end
            end
            S_RESP: begin
                rsp_valid = 1'b1;
                rsp_q     = r_quo;
                rsp_r     = r_rem;
                rsp_dbz   = r_dbz;
                if (rsp_ready) begin
                    w_next = S_IDLE;
                end
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    assign rsp_id = r_rsp_id;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_cnt    <= '0;
            r_ptr    <= 1'b1;
            r_id     <= 1'b0;
            r_rsp_id <= 1'b0;
            r_b      <= '0;
            r_rem    <= '0;
            r_quo    <= '0;
            r_dbz    <= 1'b0;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    if (w_acc) begin
                        r_b   <= w_acc_b;
                        r_id  <= w_acc_id;
                        r_ptr <= w_acc_id;
                        if (w_acc_b == '0) begin
                            r_quo    <= '1;
                            r_rem    <= w_acc_a;
                            r_dbz    <= 1'b1;
                            r_cnt    <= '0;
                            r_rsp_id <= w_acc_id;
                        end else begin
                            r_quo <= w_acc_a;
                            r_rem <= '0;
                            r_dbz <= 1'b0;
                            r_cnt <= CW'(width);
                        end
                    end
                end
                S_CALC: begin
                    r_rem <= w_fit ? w_trial[width-1:0] : w_sh[width-1:0];
                    r_quo <= {r_quo[width-2:0], w_fit};
                    r_cnt <= r_cnt - CW'(1);
                    if (w_last) begin
                        r_rsp_id <= r_id;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_div_rr_scheduler.sv
// Directed and random transactions against a behavioural divide and
// round-robin model; every comparison is an immediate assertion.
module tb_div_rr_scheduler;

    localparam int W = 4;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         req0_valid, req1_valid;
    logic         req0_ready, req1_ready;
    logic [W-1:0] req0_a, req0_b, req1_a, req1_b;
    logic         rsp_valid, rsp_ready, rsp_id, rsp_dbz, busy;
    logic [W-1:0] rsp_q, rsp_r;

    int checks = 0;
    int errors = 0;
    int last_g = 1;

    always #5 clk = ~clk;

    div_rr_scheduler #(.width(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req0_valid(req0_valid),
        .req0_ready(req0_ready),
        .req0_a    (req0_a),
        .req0_b    (req0_b),
        .req1_valid(req1_valid),
        .req1_ready(req1_ready),
        .req1_a    (req1_a),
        .req1_b    (req1_b),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_id    (rsp_id),
        .rsp_q     (rsp_q),
        .rsp_r     (rsp_r),
        .rsp_dbz   (rsp_dbz),
        .busy      (busy)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic scramble;
        req0_valid = 1'($urandom_range(0, 1));
        req1_valid = 1'($urandom_range(0, 1));
        req0_a     = W'($urandom);
        req0_b     = W'($urandom);
        req1_a     = W'($urandom);
        req1_b     = W'($urandom);
    endtask

    task automatic check_quiet(input string tag);
        chk({tag, "_valid"}, rsp_valid, 0);
        chk({tag, "_q"}, rsp_q, 0);
        chk({tag, "_r"}, rsp_r, 0);
        chk({tag, "_dbz"}, rsp_dbz, 0);
        chk({tag, "_busy"}, busy, 0);
    endtask

    task automatic do_txn(input bit v0, input bit v1,
                          input int a0, input int b0,
                          input int a1, input int b1,
                          input int stall);
        int g, a, b, n;
        logic [31:0] eq, er, ed;
        g = (v0 && v1) ? ((last_g == 1) ? 0 : 1) : (v0 ? 0 : 1);
        a = g ? a1 : a0;
        b = g ? b1 : b0;
        eq = (b == 0) ? ((1 << W) - 1) : (a / b);
        er = (b == 0) ? a : (a % b);
        ed = (b == 0) ? 1 : 0;
        req0_valid = v0;
        req1_valid = v1;
        req0_a = a0[W-1:0];
        req0_b = b0[W-1:0];
        req1_a = a1[W-1:0];
        req1_b = b1[W-1:0];
        rsp_ready = 1'b0;
        #1;
        chk("grant0", req0_ready, (g == 0));
        chk("grant1", req1_ready, (g == 1));
        tick;
        last_g = g;
        n = 1;
        while (!rsp_valid && n < 64) begin
            chk("calc_busy", busy, 1);
            chk("calc_readys", {req0_ready, req1_ready}, 0);
            scramble;
            tick;
            n++;
        end
        chk("latency", n, (b == 0) ? 1 : W + 1);
        chk("rsp_q", rsp_q, eq);
        chk("rsp_r", rsp_r, er);
        chk("rsp_dbz", rsp_dbz, ed);
        chk("rsp_id", rsp_id, g);
        for (int i = 0; i < stall; i++) begin
            scramble;
            tick;
            chk("hold_valid", rsp_valid, 1);
            chk("hold_q", rsp_q, eq);
            chk("hold_r", rsp_r, er);
            chk("hold_dbz", rsp_dbz, ed);
            chk("hold_id", rsp_id, g);
            chk("hold_readys", {req0_ready, req1_ready}, 0);
        end
        rsp_ready  = 1'b1;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        tick;
        rsp_ready = 1'b0;
        check_quiet("after");
        chk("after_id", rsp_id, g);
    endtask

    initial begin
        int m, a0, b0, a1, b1;
        rst_n = 1'b0;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        req0_a = '0;
        req0_b = '0;
        req1_a = '0;
        req1_b = '0;
        rsp_ready = 1'b0;
        tick;
        check_quiet("reset");
        chk("reset_id", rsp_id, 0);
        req0_valid = 1'b1;
        #1;
        chk("reset_ready0", req0_ready, 1);
        chk("reset_ready1", req1_ready, 0);
        req0_valid = 1'b0;
        tick;
        rst_n = 1'b1;
        #1;
        check_quiet("post_reset");
        tick;
        check_quiet("post_reset2");

        do_txn(1, 0, 7, 2, 0, 0, 0);
        do_txn(0, 1, 0, 0, 15, 1, 0);
        do_txn(0, 1, 0, 0, 0, 5, 0);
        do_txn(1, 0, 9, 0, 0, 0, 0);
        do_txn(1, 1, 14, 3, 11, 4, 0);
        do_txn(1, 1, 6, 5, 15, 15, 0);
        do_txn(1, 1, 1, 2, 12, 0, 0);
        do_txn(1, 1, 15, 7, 8, 1, 0);
        do_txn(1, 0, 13, 3, 0, 0, 10);

        // Abort req0 in the middle of CALC; the tie after reset must go to req0.
        req0_valid = 1'b1;
        req0_a = 4'd11;
        req0_b = 4'd3;
        req1_valid = 1'b0;
        #1;
        chk("abort_grant", req0_ready, 1);
        tick;
        req0_valid = 1'b0;
        tick;
        tick;
        chk("abort_busy", busy, 1);
        rst_n = 1'b0;
        tick;
        rst_n = 1'b1;
        last_g = 1;
        check_quiet("abort");
        chk("abort_id", rsp_id, 0);
        for (int i = 0; i < 8; i++) begin
            tick;
            chk("abort_no_rsp", rsp_valid, 0);
        end
        do_txn(1, 1, 11, 3, 5, 2, 0);

        for (int k = 0; k < 40; k++) begin
            m  = $urandom_range(1, 3);
            a0 = $urandom_range(0, (1 << W) - 1);
            a1 = $urandom_range(0, (1 << W) - 1);
            b0 = ($urandom_range(0, 5) == 0) ? 0 : $urandom_range(1, (1 << W) - 1);
            b1 = ($urandom_range(0, 5) == 0) ? 0 : $urandom_range(1, (1 << W) - 1);
            do_txn(m[0], m[1], a0, b0, a1, b1, $urandom_range(0, 3));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
